// File: rtl/motion_compensator_if.sv
// rtl/motion_compensator_if.sv - request, search-memory, residual and output signals of the motion compensator
interface motion_compensator_if;
  logic       start;
  logic       pred_only;
  logic [3:0] motionX;
  logic [3:0] motionY;
  logic       busy;
  logic       done;
  logic [9:0] AddressS;
  logic       s_rd;
  logic [7:0] S;
  logic       res_valid;
  logic [8:0] res_data;
  logic       res_ready;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_pixel;
  logic [7:0] out_index;
  logic       out_last;

  modport slave (
    input  start, pred_only, motionX, motionY, S, res_valid, res_data, out_ready,
    output busy, done, AddressS, s_rd, res_ready, out_valid, out_pixel, out_index, out_last
  );

  modport master (
    output start, pred_only, motionX, motionY, S, res_valid, res_data, out_ready,
    input  busy, done, AddressS, s_rd, res_ready, out_valid, out_pixel, out_index, out_last
  );
endinterface

// File: rtl/motion_compensator.sv
// rtl/motion_compensator.sv - fetch predicted 16x16 block, add residual, saturate, stream out
module motion_compensator #(
  parameter int MEM_LAT    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input logic                 clock,
  input logic                 reset_n,
  motion_compensator_if.slave mc
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state;
  logic [3:0]         off_x;
  logic [3:0]         off_y;
  logic               pred_only_q;
  logic [8:0]         issued;
  logic [8:0]         issued_next;
  logic [CW-1:0]      occ;
  logic [CW-1:0]      occ_next;
  logic [CW-1:0]      fifo_count;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [MEM_LAT-1:0] pipe;
  logic [7:0]         pop_cnt;
  logic               arrive;
  logic               fifo_has;
  logic               pop;
  logic               push;
  logic               fifo_pop;
  logic [7:0]         head;
  logic [7:0]         recon;
  logic [8:0]         res_eff;
  logic [9:0]         sum;

  // Row and column never exceed 30, so a 5-bit row shifted by 5 plus a 5-bit column fits 10 bits.
  function automatic logic [9:0] addr_of(input logic [3:0] ox, input logic [3:0] oy,
                                         input logic [7:0] idx);
    logic [4:0] row;
    logic [4:0] col;
    row = {1'b0, oy} + {1'b0, idx[7:4]};
    col = {1'b0, ox} + {1'b0, idx[3:0]};
    return {row, 5'b00000} + {5'b00000, col};
  endfunction

  // Pop pairing, fall-through head selection, saturation and occupancy bookkeeping.
  always_comb begin
    arrive      = pipe[MEM_LAT-1];
    fifo_has    = (fifo_count != '0);
    head        = fifo_has ? fifo_mem[rd_ptr] : mc.S;
    pop         = ((state == RUN) || (state == DRAIN)) && (fifo_has || arrive) &&
                  (pred_only_q || mc.res_valid) && (!mc.out_valid || mc.out_ready);
    fifo_pop    = pop && fifo_has;
    push        = arrive && !(pop && !fifo_has);
    res_eff     = pred_only_q ? 9'd0 : mc.res_data;
    sum         = {2'b00, head} + {res_eff[8], res_eff};
    recon       = sum[9] ? 8'd0 : (sum[8] ? 8'hFF : sum[7:0]);
    issued_next = issued + {8'd0, mc.s_rd};
    occ_next    = occ + {{(CW-1){1'b0}}, mc.s_rd} - {{(CW-1){1'b0}}, pop};
  end

  assign mc.res_ready = pop && !pred_only_q;

  // Block sequencer: vector latch, read issue with occupancy credit, done pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      off_x       <= 4'd0;
      off_y       <= 4'd0;
      pred_only_q <= 1'b0;
      issued      <= 9'd0;
      occ         <= '0;
      mc.busy     <= 1'b0;
      mc.done     <= 1'b0;
      mc.s_rd     <= 1'b0;
      mc.AddressS <= 10'd0;
    end else begin
      mc.done <= 1'b0;
      case (state)
        IDLE: begin
          if (mc.start) begin
            off_x       <= mc.motionX + 4'd8;
            off_y       <= mc.motionY + 4'd9;
            pred_only_q <= mc.pred_only;
            issued      <= 9'd0;
            occ         <= '0;
            mc.busy     <= 1'b1;
            mc.s_rd     <= 1'b1;
            mc.AddressS <= addr_of(mc.motionX + 4'd8, mc.motionY + 4'd9, 8'd0);
            state       <= RUN;
          end
        end
        RUN: begin
          issued <= issued_next;
          occ    <= occ_next;
          if (issued_next == 9'd256) begin
            mc.s_rd <= 1'b0;
            state   <= DRAIN;
          end else if (occ_next < DEPTH_C) begin
            mc.s_rd     <= 1'b1;
            mc.AddressS <= addr_of(off_x, off_y, issued_next[7:0]);
          end else begin
            mc.s_rd <= 1'b0;
          end
        end
        DRAIN: begin
          occ <= occ_next;
          if (mc.out_valid && mc.out_ready && mc.out_last) begin
            mc.busy <= 1'b0;
            mc.done <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Read-return tracker: a bit per in-flight read, emerging when S is valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe <= '0;
    end else begin
      pipe[0] <= mc.s_rd;
      for (int i = 1; i < MEM_LAT; i++) pipe[i] <= pipe[i-1];
    end
  end

  // Prediction FIFO pointers and fill level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + {{(CW-1){1'b0}}, push} - {{(CW-1){1'b0}}, fifo_pop};
    end
  end

  // Prediction FIFO storage.
  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= mc.S;
  end

  // Output register: loads on pop, holds under backpressure, clears once accepted.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pop_cnt      <= 8'd0;
      mc.out_valid <= 1'b0;
      mc.out_pixel <= 8'd0;
      mc.out_index <= 8'd0;
      mc.out_last  <= 1'b0;
    end else if ((state == IDLE) && mc.start) begin
      pop_cnt <= 8'd0;
    end else if (pop) begin
      mc.out_pixel <= recon;
      mc.out_index <= pop_cnt;
      mc.out_last  <= (pop_cnt == 8'd255);
      mc.out_valid <= 1'b1;
      pop_cnt      <= pop_cnt + 8'd1;
    end else if (mc.out_ready) begin
      mc.out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_motion_compensator.sv
// tb/tb_motion_compensator.sv - directed-vector bench for motion_compensator
module tb_motion_compensator;
  localparam int MEM_LAT    = 1;
  localparam int FIFO_DEPTH = 4;

  logic clock = 1'b0;
  logic reset_n;

  motion_compensator_if mc();

  motion_compensator #(.MEM_LAT(MEM_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .mc     (mc)
  );

  always #5 clock = ~clock;

  logic [7:0] smem [1024];
  logic [8:0] res_tab [256];
  logic [7:0] s_pipe [MEM_LAT];
  logic [8:0] res_cnt;
  int         cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    s_pipe[0] <= smem[mc.AddressS];
    for (int i = 1; i < MEM_LAT; i++) s_pipe[i] <= s_pipe[i-1];
  end

  assign mc.S        = s_pipe[MEM_LAT-1];
  assign mc.res_data = res_tab[res_cnt[7:0]];

  int vectors = 0;
  int miscompares = 0;

  int cur_mx, cur_my, start_cyc;
  bit cur_po, cur_stall, cur_rnd, cur_mid;

  int rd_cnt, out_cnt, first_rd_rel, first_ov_rel, first_addr, last_addr, max_addr;
  int addr_err, hold_err, last_cnt, last_bad, ready_bad, res_total, done_cnt, done_rel;
  int max_occ, stall_srd;
  bit hold_prev, res_take;
  logic [7:0] hold_pix, hold_idx;
  logic [7:0] got_pix [256];
  logic [7:0] got_idx [256];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_addr(input int mx, input int my, input int i);
    return (((my + 9) & 15) + i / 16) * 32 + ((mx + 8) & 15) + i % 16;
  endfunction

  function automatic int model_pix(input int i);
    int v;
    v = int'(smem[exp_addr(cur_mx, cur_my, i)]);
    if (cur_po) return v;
    v = v + int'($signed(res_tab[i]));
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  task automatic init_mem();
    for (int a = 0; a < 1024; a++) smem[a] = a[7:0];
  endtask

  task automatic rand_res();
    for (int i = 0; i < 256; i++) res_tab[i] = 9'($urandom_range(0, 511));
  endtask

  task automatic sample();
    int rel, occ_now;
    rel = cyc - start_cyc;
    if (mc.s_rd) begin
      if (rd_cnt == 0) begin
        first_rd_rel = rel;
        first_addr   = int'(mc.AddressS);
      end
      last_addr = int'(mc.AddressS);
      if (int'(mc.AddressS) > max_addr) max_addr = int'(mc.AddressS);
      if (rd_cnt < 256 && int'(mc.AddressS) != exp_addr(cur_mx, cur_my, rd_cnt)) addr_err++;
    end
    occ_now = rd_cnt + int'(mc.s_rd) - (out_cnt + int'(mc.out_valid));
    if (occ_now > max_occ) max_occ = occ_now;
    if (mc.s_rd) rd_cnt++;
    if (cur_stall && rel == 79) stall_srd = int'(mc.s_rd);
    if (mc.out_valid) begin
      if (first_ov_rel < 0) first_ov_rel = rel;
      if (hold_prev && (mc.out_pixel !== hold_pix || mc.out_index !== hold_idx)) hold_err++;
    end
    hold_prev = mc.out_valid && !mc.out_ready;
    hold_pix  = mc.out_pixel;
    hold_idx  = mc.out_index;
    if (mc.out_valid && mc.out_ready) begin
      if (out_cnt < 256) begin
        got_pix[out_cnt] = mc.out_pixel;
        got_idx[out_cnt] = mc.out_index;
      end
      if (mc.out_last) begin
        last_cnt++;
        if (mc.out_index != 8'd255) last_bad++;
      end
      out_cnt++;
    end
    if (mc.res_ready && (!mc.res_valid || cur_po || (mc.out_valid && !mc.out_ready))) ready_bad++;
    res_take = mc.res_valid && mc.res_ready;
    if (res_take) res_total++;
    if (mc.done) begin
      done_cnt++;
      done_rel = rel;
    end
  endtask

  task automatic drive();
    int rel;
    rel = cyc - start_cyc;
    mc.start     = 1'b0;
    mc.out_ready = !(cur_stall && rel >= 60 && rel < 80);
    mc.res_valid = cur_rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    if (cur_mid && rel == 50) begin
      mc.start   = 1'b1;
      mc.motionX = 4'd9;
      mc.motionY = 4'd9;
    end
    if (cur_mid && mc.done) begin
      mc.start   = 1'b1;
      mc.motionX = 4'd7;
      mc.motionY = 4'd7;
    end
  endtask

  task automatic step();
    @(negedge clock);
    sample();
    @(posedge clock);
    #1;
    if (res_take) res_cnt = res_cnt + 9'd1;
    drive();
  endtask

  task automatic begin_block(input int mx, input int my, input bit po,
                             input bit stall, input bit rnd, input bit mid);
    cur_mx = mx; cur_my = my; cur_po = po;
    cur_stall = stall; cur_rnd = rnd; cur_mid = mid;
    rd_cnt = 0; out_cnt = 0; first_rd_rel = -1; first_ov_rel = -1;
    first_addr = -1; last_addr = -1; max_addr = 0; addr_err = 0; hold_err = 0;
    last_cnt = 0; last_bad = 0; ready_bad = 0; res_total = 0; done_cnt = 0;
    done_rel = -1; max_occ = 0; stall_srd = 2; hold_prev = 1'b0; res_take = 1'b0;
    for (int i = 0; i < 256; i++) begin
      got_pix[i] = 8'd0;
      got_idx[i] = 8'd0;
    end
    res_cnt      = 9'd0;
    mc.motionX   = 4'(mx);
    mc.motionY   = 4'(my);
    mc.pred_only = po;
    mc.out_ready = 1'b1;
    mc.res_valid = 1'b1;
    mc.start     = 1'b1;
    start_cyc    = cyc;
  endtask

  task automatic run_block(input string nm, input int mx, input int my, input bit po,
                           input bit stall, input bit rnd, input bit mid);
    int n, idx_err, pix_err;
    begin_block(mx, my, po, stall, rnd, mid);
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      step();
      n++;
    end
    check_eq({nm, "_done_pulses"}, done_cnt, 1);
    if (mid) check_eq({nm, "_start_in_done_ignored"}, mc.busy, 0);
    idx_err = 0;
    pix_err = 0;
    for (int i = 0; i < 256; i++) begin
      if (got_idx[i] !== 8'(i)) idx_err++;
      if (int'(got_pix[i]) != model_pix(i)) pix_err++;
    end
    check_eq({nm, "_beats"}, out_cnt, 256);
    check_eq({nm, "_reads"}, rd_cnt, 256);
    check_eq({nm, "_index_order_errs"}, idx_err, 0);
    check_eq({nm, "_pixel_errs"}, pix_err, 0);
    check_eq({nm, "_addr_errs"}, addr_err, 0);
    check_eq({nm, "_last_count"}, last_cnt, 1);
    check_eq({nm, "_last_bad"}, last_bad, 0);
    check_eq({nm, "_hold_errs"}, hold_err, 0);
    check_eq({nm, "_occ_bound"}, max_occ <= FIFO_DEPTH, 1);
    check_eq({nm, "_res_consumed"}, res_total, po ? 0 : 256);
    check_eq({nm, "_res_ready_bad"}, ready_bad, 0);
  endtask

  initial begin
    int n, dn;
    reset_n      = 1'b0;
    mc.start     = 1'b0;
    mc.pred_only = 1'b0;
    mc.motionX   = 4'd0;
    mc.motionY   = 4'd0;
    mc.res_valid = 1'b0;
    mc.out_ready = 1'b1;
    res_cnt      = 9'd0;
    start_cyc    = 0;
    init_mem();
    rand_res();
    repeat (3) @(posedge clock);
    #1;
    check_eq("reset_ctrl", {mc.busy, mc.done, mc.s_rd, mc.res_ready, mc.out_valid, mc.out_last}, 0);
    check_eq("reset_addr", mc.AddressS, 0);
    check_eq("reset_data", {mc.out_pixel, mc.out_index}, 0);
    reset_n = 1'b1;

    run_block("pass0", 0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("pass0_first_rd_cycle", first_rd_rel, 1);
    check_eq("pass0_first_addr", first_addr, 296);
    check_eq("pass0_last_addr", last_addr, 791);
    check_eq("pass0_first_out_cycle", first_ov_rel, 3);
    check_eq("pass0_done_cycle", done_rel, 259);
    check_eq("pass0_pix0", got_pix[0], 8'h28);
    check_eq("pass0_pix255", got_pix[255], 8'h17);

    run_block("corner", 7, 6, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("corner_first_addr", first_addr, 495);
    check_eq("corner_last_addr", last_addr, 990);
    check_eq("corner_max_addr", max_addr, 990);

    init_mem();
    rand_res();
    smem[296] = 8'd250; res_tab[0] = 9'd10;
    smem[297] = 8'd5;   res_tab[1] = 9'h1EC;
    smem[298] = 8'd100; res_tab[2] = 9'h100;
    smem[299] = 8'd0;   res_tab[3] = 9'h0FF;
    smem[300] = 8'd128; res_tab[4] = 9'd0;
    run_block("sat", 0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("sat_250p10", got_pix[0], 255);
    check_eq("sat_5m20", got_pix[1], 0);
    check_eq("sat_100m256", got_pix[2], 0);
    check_eq("sat_0p255", got_pix[3], 255);
    check_eq("sat_128p0", got_pix[4], 128);

    init_mem();
    rand_res();
    run_block("stall", 3, 4, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("stall_srd_stopped", stall_srd, 0);

    rand_res();
    run_block("rndres", 5, 13, 1'b0, 1'b0, 1'b1, 1'b0);

    rand_res();
    run_block("midstart", 2, 3, 1'b0, 1'b0, 1'b0, 1'b1);
    check_eq("midstart_first_addr", first_addr, exp_addr(2, 3, 0));

    rand_res();
    begin_block(1, 2, 1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (out_cnt < 100 && n < 1000) begin
      step();
      n++;
    end
    check_eq("abort_reached_100", out_cnt >= 100, 1);
    reset_n = 1'b0;
    #1;
    check_eq("abort_ctrl", {mc.busy, mc.done, mc.s_rd, mc.res_ready, mc.out_valid, mc.out_last}, 0);
    check_eq("abort_addr", mc.AddressS, 0);
    check_eq("abort_data", {mc.out_pixel, mc.out_index}, 0);
    dn = 0;
    repeat (4) begin
      @(negedge clock);
      if (mc.done) dn++;
    end
    @(posedge clock);
    #1;
    mc.start = 1'b0;
    reset_n  = 1'b1;
    repeat (2) begin
      @(negedge clock);
      if (mc.done) dn++;
      @(posedge clock);
      #1;
    end
    check_eq("abort_no_done", dn, 0);
    check_eq("abort_idle", mc.busy, 0);

    run_block("fresh", 3, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    check_eq("fresh_first_addr", first_addr, 363);
    check_eq("fresh_first_index", got_idx[0], 0);
    check_eq("fresh_first_rd_cycle", first_rd_rel, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
